// File: rtl/rtc_edit_pkg.sv
// Shared definitions for the RTC field editor: FSM encoding, field codes,
// bus address table and per-field BCD ranges.
package rtc_edit_pkg;

  localparam int FIELD_COUNT = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_EDIT    = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5
  } state_t;

  localparam logic [3:0] F_SEG      = 4'd1;
  localparam logic [3:0] F_MIN      = 4'd2;
  localparam logic [3:0] F_HORA     = 4'd3;
  localparam logic [3:0] F_DIA      = 4'd4;
  localparam logic [3:0] F_MES      = 4'd5;
  localparam logic [3:0] F_YEAR     = 4'd6;
  localparam logic [3:0] F_TMR_SEG  = 4'd7;
  localparam logic [3:0] F_TMR_MIN  = 4'd8;
  localparam logic [3:0] F_TMR_HORA = 4'd9;

  // Shadow index of the calendar fields involved in month-length handling.
  localparam logic [3:0] I_DIA  = 4'd3;
  localparam logic [3:0] I_MES  = 4'd4;
  localparam logic [3:0] I_YEAR = 4'd5;

  // Element 0 is field code 1 (seg); tables are listed highest index first.
  localparam logic [FIELD_COUNT-1:0][7:0] ADDR = {
    8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };
  localparam logic [FIELD_COUNT-1:0][7:0] FMIN = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00
  };
  localparam logic [FIELD_COUNT-1:0][7:0] FMAX = {
    8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59
  };

  // Days in month as BCD; unknown month codes fall back to 31.
  function automatic logic [7:0] month_days(input logic [7:0] mes, input logic [7:0] year);
    logic [6:0] yr_bin;
    yr_bin = ({3'b000, year[7:4]} * 7'd10) + {3'b000, year[3:0]};
    case (mes)
      8'h02:                      month_days = (yr_bin[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_days = 8'h30;
      default:                    month_days = 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/bcd_wrap_step.sv
// One BCD up/down step with wrap-around inside [min_val, max_val].
// Out-of-range or non-BCD values snap to min_val on any step.
module bcd_wrap_step (
  input  logic [7:0] value,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  logic       up,
  input  logic       dn,
  output logic [7:0] next_val
);

  logic in_range;

  always_comb begin
    in_range = (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) &&
               (value >= min_val) && (value <= max_val);
    next_val = value;
    if (up ^ dn) begin
      if (!in_range) begin
        next_val = min_val;
      end else if (up) begin
        if (value == max_val)
          next_val = min_val;
        else if (value[3:0] == 4'd9)
          next_val = {value[7:4] + 4'd1, 4'd0};
        else
          next_val = {value[7:4], value[3:0] + 4'd1};
      end else begin
        if (value == min_val)
          next_val = max_val;
        else if (value[3:0] == 4'd0)
          next_val = {value[7:4] - 4'd1, 4'd9};
        else
          next_val = {value[7:4], value[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// RTC edit-session sequencer: bulk read into shadows, button editing, bulk write-back.
// Build option RTC_EDIT_MONTH_DAYS_EN: dia wraps/clamps at the real month length.
//
// state     | meaning
// S_IDLE    | waiting for an edit_en rise
// S_RD_REQ  | read request for field idx
// S_RD_WAIT | waiting for read ack or timeout
// S_EDIT    | shadows editable by arriba/abajo
// S_WR_REQ  | write request for field idx
// S_WR_WAIT | waiting for write ack or timeout
module rtc_field_editor
  import rtc_edit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int NFIELDS     = FIELD_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_en,
  input  logic [3:0] puntero,
  input  logic       arriba,
  input  logic       abajo,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic [7:0] field_val,
  output logic       busy,
  output logic       done,
  output logic       bus_err
);

  localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMR_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NFIELDS - 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          edit_en_q, edit_rise;
  logic          done_d, timeout;
  logic [7:0]    shadow_q [NFIELDS];

  logic          sel_valid, edit_act, edit_wr;
  logic [3:0]    sel;
  logic [7:0]    cur_val, min_sel, max_sel, step_val;

  assign edit_rise = edit_en & ~edit_en_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edit_rise) begin
          state_d = S_RD_REQ;
          idx_d   = '0;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        tmr_d   = TMR_LOAD;
      end
      S_RD_WAIT: begin
        if (bus_ack || (tmr_q == '0)) begin
          timeout = ~bus_ack;
          if (!edit_en) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_EDIT;
            idx_d   = '0;
          end else begin
            state_d = S_RD_REQ;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_EDIT: begin
        if (!edit_en) begin
          state_d = S_WR_REQ;
          idx_d   = '0;
        end
      end
      S_WR_REQ: begin
        state_d = S_WR_WAIT;
        tmr_d   = TMR_LOAD;
      end
      S_WR_WAIT: begin
        if (bus_ack || (tmr_q == '0)) begin
          timeout = ~bus_ack;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_WR_REQ;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 8'h00;
    bus_wdata = 8'h00;
    case (state_q)
      S_RD_REQ, S_RD_WAIT: begin
        bus_req  = 1'b1;
        bus_addr = ADDR[idx_q];
      end
      S_WR_REQ, S_WR_WAIT: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR[idx_q];
        bus_wdata = shadow_q[idx_q];
      end
      default: ;
    endcase
  end

  assign busy = bus_req;

  // Field selection and edit step
  always_comb begin
    sel_valid = (puntero >= F_SEG) && (puntero <= F_TMR_HORA);
    sel       = sel_valid ? (puntero - 4'd1) : 4'd0;
    cur_val   = shadow_q[sel];
    min_sel   = FMIN[sel];
    max_sel   = FMAX[sel];
`ifdef RTC_EDIT_MONTH_DAYS_EN
    if (puntero == F_DIA)
      max_sel = month_days(shadow_q[I_MES], shadow_q[I_YEAR]);
`endif
    edit_act  = (state_q == S_EDIT) && sel_valid;
    edit_wr   = edit_act && (arriba ^ abajo);
    field_val = sel_valid ? cur_val : 8'h00;
  end

  bcd_wrap_step u_step (
    .value   (cur_val),
    .min_val (min_sel),
    .max_val (max_sel),
    .up      (arriba & edit_act),
    .dn      (abajo & edit_act),
    .next_val(step_val)
  );

`ifdef RTC_EDIT_MONTH_DAYS_EN
  logic [7:0] new_mes, new_year, dia_lim;
  logic       dia_clamp;

  // A month or year edit may shorten the month; pull dia down in the same cycle.
  always_comb begin
    new_mes   = (puntero == F_MES)  ? step_val : shadow_q[I_MES];
    new_year  = (puntero == F_YEAR) ? step_val : shadow_q[I_YEAR];
    dia_lim   = month_days(new_mes, new_year);
    dia_clamp = edit_wr && ((puntero == F_MES) || (puntero == F_YEAR)) &&
                (shadow_q[I_DIA] > dia_lim);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      edit_en_q <= 1'b0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      for (int i = 0; i < NFIELDS; i++) shadow_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      edit_en_q <= edit_en;
      done      <= done_d;
      if (timeout)
        bus_err <= 1'b1;
      else if (edit_rise)
        bus_err <= 1'b0;
      if ((state_q == S_RD_WAIT) && bus_ack)
        shadow_q[idx_q] <= bus_rdata;
      if (edit_wr)
        shadow_q[sel] <= step_val;
`ifdef RTC_EDIT_MONTH_DAYS_EN
      if (dia_clamp)
        shadow_q[I_DIA] <= dia_lim;
`endif
    end
  end

endmodule
